// File: rtl/izz_pkg.sv
// Shared definitions for the inverse-zigzag lane splitter.
package izz_pkg;

  typedef logic [2:0] izz_lane_t;

  localparam izz_lane_t LANE_A = 3'd0;
  localparam izz_lane_t LANE_B = 3'd1;
  localparam izz_lane_t LANE_C = 3'd2;
  localparam izz_lane_t LANE_D = 3'd3;
  localparam izz_lane_t LANE_E = 3'd4;
  localparam izz_lane_t LANE_F = 3'd5;
  localparam izz_lane_t LANE_G = 3'd6;
  localparam izz_lane_t LANE_H = 3'd7;

  localparam logic STATECASE_STALL = 1'b0;
  localparam logic STATECASE_FIRE  = 1'b1;

  localparam int IZZ_BLOCK_SIZE = 64;

endpackage

// File: rtl/izz_sat_counter.sv
// Event counter. SATURATE=1 sticks at all-ones, SATURATE=0 wraps.
module izz_sat_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step on inc unless saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(SATURATE && (&cnt_q))) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/izigzag_seq_ctl.sv
// Control half of the inverse-zigzag lane splitter: walks lanes A..H, PER_VISIT
// tokens per lane, gating each fire on stream data and current-lane space.
// Optional statistics outputs are built when IZZ_SEQ_STATS_EN is defined.
module izigzag_seq_ctl
  import izz_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int PER_VISIT  = 2,
  parameter int BLOCK_SIZE = IZZ_BLOCK_SIZE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_consume,
  input  logic [NUM_LANES-1:0]          lane_full,
  output logic [NUM_LANES-1:0]          lane_wr,
  output logic [$clog2(NUM_LANES)-1:0]  state,
  output logic                          statecase,
  output logic [$clog2(BLOCK_SIZE)-1:0] index,
  output logic                          block_done
`ifdef IZZ_SEQ_STATS_EN
  ,
  output logic [15:0]                   stall_cnt,
  output logic [15:0]                   blk_cnt
`endif
);

  localparam int SW = $clog2(NUM_LANES);
  localparam int IW = $clog2(BLOCK_SIZE);
  localparam int PW = (PER_VISIT > 1) ? $clog2(PER_VISIT) : 1;

  localparam logic [SW-1:0] ST_LAST  = SW'(NUM_LANES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(PER_VISIT - 1);

  // Blocks must hold a whole number of full lane sweeps so every block starts on lane A.
  if (BLOCK_SIZE % (NUM_LANES * PER_VISIT) != 0) begin : g_bad_cfg
    $error("izigzag_seq_ctl: BLOCK_SIZE must be a multiple of NUM_LANES*PER_VISIT");
  end

  logic [SW-1:0] state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [IW-1:0] index_q, index_d;
  logic          fire;
  logic          last_tok;

  // Fire decision and next-state; reset masks fire so outputs drop without a clock edge.
  always_comb begin
    fire     = in_valid & ~lane_full[state_q] & ~reset;
    last_tok = (index_q == IDX_LAST);
    state_d  = state_q;
    phase_d  = phase_q;
    index_d  = index_q;
    if (fire) begin
      index_d = last_tok ? '0 : index_q + 1'b1;
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (phase_q == PH_LAST) state_d = (state_q == ST_LAST) ? '0 : state_q + 1'b1;
    end
  end

  // Lane / phase / block-position registers; they only move on a fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SW'(LANE_A);
      phase_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      index_q <= index_d;
    end
  end

  assign statecase  = fire ? STATECASE_FIRE : STATECASE_STALL;
  assign in_consume = fire;
  assign lane_wr    = fire ? (NUM_LANES'(1) << state_q) : '0;
  assign block_done = fire & last_tok;
  assign state      = state_q;
  assign index      = index_q;

`ifdef IZZ_SEQ_STATS_EN
  izz_sat_counter #(.W(16), .SATURATE(1'b1)) u_stall_cnt (
    .clk   (clock),
    .rst   (reset),
    .inc_i (in_valid & ~fire),
    .cnt_o (stall_cnt)
  );

  izz_sat_counter #(.W(16), .SATURATE(1'b0)) u_blk_cnt (
    .clk   (clock),
    .rst   (reset),
    .inc_i (block_done),
    .cnt_o (blk_cnt)
  );
`endif

endmodule
